// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
package serial_sub_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width: $clog2 collapses to 0 for a one-bit operand, so floor it at 1.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requesting datapath and serial_sub_ctrl.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Purely combinational one-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: walks one fs_cell across WIDTH-bit operands, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int CW = cntWidth(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_diffSh;
  logic [WIDTH-1:0] w_diffNext;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bo;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_aSign;
  logic             r_bSign;
  logic             r_ovf;
`endif

  fs_cell u_cell (
    .x  (r_aSh[0]),
    .y  (r_bSh[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
  assign w_diffNext = (r_diffSh >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results are committed on the final shift edge so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh    <= '0;
      r_bSh    <= '0;
      r_diffSh <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_aSign  <= 1'b0;
      r_bSign  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_aSh    <= bus.a;
        r_bSh    <= bus.b;
        r_diffSh <= '0;
        r_borrow <= bus.bin;
        r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
        r_aSign  <= bus.a[WIDTH-1];
        r_bSign  <= bus.b[WIDTH-1];
`endif
      end else if (r_state == SHIFT) begin
        r_aSh    <= r_aSh >> 1;
        r_bSh    <= r_bSh >> 1;
        r_diffSh <= w_diffNext;
        r_borrow <= w_bo;
        r_cnt    <= r_cnt + CW'(1);
      end

      if (w_last) begin
        r_diff <= w_diffNext;
        r_bout <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
        r_ovf  <= (r_aSign ^ r_bSign) & (r_aSign ^ w_diffNext[WIDTH-1]);
`endif
      end

      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule
